// File: rtl/trig_pkg.sv
// Shared constants, field positions and state/requester enums for the
// hardware-trigger CSR block.
package trig_pkg;

  localparam logic [11:0] CSR_TSELECT = 12'h7A0;
  localparam logic [11:0] CSR_TDATA1  = 12'h7A1;
  localparam logic [11:0] CSR_TDATA2  = 12'h7A2;
  localparam logic [11:0] CSR_TDATA3  = 12'h7A3;

  localparam int unsigned TDATA1_TYPE_LSB = 28;
  localparam int unsigned TDATA1_DMODE    = 27;
  localparam int unsigned TDATA1_HIT      = 20;

  localparam logic [31:0] TDATA1_RST   = 32'h2 << TDATA1_TYPE_LSB;
  // Software-writable tdata1 bits: excludes type, dmode, bit 19 and bits 5:3
  localparam logic [31:0] TDATA1_WMASK = 32'h07F7_FFC7;

  typedef enum logic [1:0] {ACC_IDLE, ACC_GNT, ACC_RESP} acc_state_e;
  typedef enum logic [1:0] {HIT_IDLE, HIT_REQ, HIT_HALTED} hit_state_e;
  typedef enum logic {REQ_CORE, REQ_DM} req_id_e;

  function automatic logic [31:0] tdata1_merge(input logic [31:0] cur,
                                               input logic [31:0] wdata,
                                               input logic        dmode_ok);
    logic [31:0] v;
    v = TDATA1_RST | (wdata & TDATA1_WMASK);
    v[TDATA1_DMODE] = dmode_ok ? wdata[TDATA1_DMODE] : cur[TDATA1_DMODE];
    return v;
  endfunction

endpackage

// File: rtl/trig_csr_arb.sv
// CSR requester arbitration: fixed DM priority by default, round-robin on
// contention when TRIG_ARB_RR_EN is defined.
module trig_csr_arb
  import trig_pkg::*;
(
`ifdef TRIG_ARB_RR_EN
  input  logic    clk,
  input  logic    rst,
`endif
  input  logic    idle,
  input  logic    core_req,
  input  logic    dm_req,
  output req_id_e winner,
  output logic    latch
);

  assign latch = idle && (core_req || dm_req);

`ifdef TRIG_ARB_RR_EN
  req_id_e last_q;

  always_comb begin
    winner = REQ_CORE;
    if (dm_req && core_req)
      winner = (last_q == REQ_CORE) ? REQ_DM : REQ_CORE;
    else if (dm_req)
      winner = REQ_DM;
  end

  // Only contended grants move the priority pointer
  always_ff @(posedge clk) begin
    if (rst)
      last_q <= REQ_CORE;
    else if (latch && dm_req && core_req)
      last_q <= winner;
  end
`else
  always_comb begin
    winner = dm_req ? REQ_DM : REQ_CORE;
  end
`endif

endmodule

// File: rtl/trig_csr_ctrl.sv
// Trigger CSR owner: core/DM access arbitration, dmode protection and the
// breakpoint-to-halt handshake. Optional macro: TRIG_ARB_RR_EN.
module trig_csr_ctrl
  import trig_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_TRIG   = 2
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rst,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [11:0]           core_addr,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  output logic                  core_gnt,
  output logic                  core_rvalid,
  output logic [DATA_WIDTH-1:0] core_rdata,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [11:0]           dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic                  dm_gnt,
  output logic                  dm_rvalid,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  input  logic                  dbg_mode,
  input  logic                  breakpoint,
  input  logic                  halt_ack,
  output logic                  tselect,
  output logic [DATA_WIDTH-1:0] tdata1,
  output logic [DATA_WIDTH-1:0] tdata2_t0,
  output logic [DATA_WIDTH-1:0] tdata2_t1,
  output logic [DATA_WIDTH-1:0] tdata3_t0,
  output logic [DATA_WIDTH-1:0] tdata3_t1,
  output logic                  halt_req,
  output logic                  hit_pending
);

  acc_state_e            acc_state;
  hit_state_e            hit_state;
  req_id_e               win_q;
  req_id_e               winner;
  logic                  latch;
  logic [11:0]           addr_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  tsel_q;
  logic [DATA_WIDTH-1:0] td1 [NUM_TRIG];
  logic [DATA_WIDTH-1:0] td2 [NUM_TRIG];
  logic [DATA_WIDTH-1:0] td3 [NUM_TRIG];

  logic                  wr_en;
  logic                  locked;
  logic                  tsel_ok;
  logic                  td_wr;
  logic [DATA_WIDTH-1:0] td1_new;
  logic [DATA_WIDTH-1:0] rd_val;

  trig_csr_arb u_arb (
`ifdef TRIG_ARB_RR_EN
    .clk      (cpu_clk),
    .rst      (cpu_rst),
`endif
    .idle     (acc_state == ACC_IDLE),
    .core_req (core_req),
    .dm_req   (dm_req),
    .winner   (winner),
    .latch    (latch)
  );

  assign tselect   = tsel_q;
  assign tdata1    = td1[tsel_q];
  assign tdata2_t0 = td2[0];
  assign tdata2_t1 = td2[1];
  assign tdata3_t0 = td3[0];
  assign tdata3_t1 = td3[1];

  always_comb begin
    wr_en   = (acc_state == ACC_GNT) && we_q;
    locked  = td1[tsel_q][TDATA1_DMODE] && !dbg_mode && (win_q == REQ_CORE);
    tsel_ok = wdata_q < DATA_WIDTH'(NUM_TRIG);
    td_wr   = wr_en && !locked;
    td1_new = tdata1_merge(td1[tsel_q], wdata_q, (win_q == REQ_DM) || dbg_mode);
  end

  // Read data reflects the value being committed in the same GNT cycle
  always_comb begin
    rd_val = '0;
    case (addr_q)
      CSR_TSELECT: rd_val = DATA_WIDTH'((wr_en && tsel_ok) ? wdata_q[0] : tsel_q);
      CSR_TDATA1:  rd_val = td_wr ? td1_new : td1[tsel_q];
      CSR_TDATA2:  rd_val = td_wr ? wdata_q : td2[tsel_q];
      CSR_TDATA3:  rd_val = td_wr ? wdata_q : td3[tsel_q];
      default:     rd_val = '0;
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      acc_state   <= ACC_IDLE;
      hit_state   <= HIT_IDLE;
      win_q       <= REQ_CORE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      tsel_q      <= 1'b0;
      core_gnt    <= 1'b0;
      core_rvalid <= 1'b0;
      core_rdata  <= '0;
      dm_gnt      <= 1'b0;
      dm_rvalid   <= 1'b0;
      dm_rdata    <= '0;
      halt_req    <= 1'b0;
      hit_pending <= 1'b0;
      for (int unsigned i = 0; i < NUM_TRIG; i++) begin
        td1[i] <= TDATA1_RST;
        td2[i] <= '0;
        td3[i] <= '0;
      end
    end else begin
      core_gnt    <= 1'b0;
      dm_gnt      <= 1'b0;
      core_rvalid <= 1'b0;
      dm_rvalid   <= 1'b0;
      core_rdata  <= '0;
      dm_rdata    <= '0;

      case (acc_state)
        ACC_IDLE: begin
          if (latch) begin
            win_q     <= winner;
            addr_q    <= (winner == REQ_DM) ? dm_addr  : core_addr;
            we_q      <= (winner == REQ_DM) ? dm_we    : core_we;
            wdata_q   <= (winner == REQ_DM) ? dm_wdata : core_wdata;
            dm_gnt    <= (winner == REQ_DM);
            core_gnt  <= (winner == REQ_CORE);
            acc_state <= ACC_GNT;
          end
        end
        ACC_GNT: begin
          if (wr_en) begin
            case (addr_q)
              CSR_TSELECT: if (tsel_ok) tsel_q <= wdata_q[0];
              CSR_TDATA1:  if (!locked) td1[tsel_q] <= td1_new;
              CSR_TDATA2:  if (!locked) td2[tsel_q] <= wdata_q;
              CSR_TDATA3:  if (!locked) td3[tsel_q] <= wdata_q;
              default: ;
            endcase
          end
          if (win_q == REQ_DM) begin
            dm_rvalid <= 1'b1;
            dm_rdata  <= rd_val;
          end else begin
            core_rvalid <= 1'b1;
            core_rdata  <= rd_val;
          end
          acc_state <= ACC_RESP;
        end
        default: acc_state <= ACC_IDLE;
      endcase

      // Placed after the CSR write so a same-cycle hardware hit set wins
      case (hit_state)
        HIT_IDLE: begin
          if (breakpoint && !dbg_mode) begin
            td1[tsel_q][TDATA1_HIT] <= 1'b1;
            halt_req    <= 1'b1;
            hit_pending <= 1'b1;
            hit_state   <= HIT_REQ;
          end
        end
        HIT_REQ: begin
          if (halt_ack) begin
            halt_req  <= 1'b0;
            hit_state <= HIT_HALTED;
          end
        end
        default: begin
          if (!dbg_mode) begin
            hit_pending <= 1'b0;
            hit_state   <= HIT_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trig_csr_ctrl.sv
// Directed self-checking bench for trig_csr_ctrl with a response scoreboard.
module tb_trig_csr_ctrl;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic        core_req, core_we, dm_req, dm_we;
  logic [11:0] core_addr, dm_addr;
  logic [31:0] core_wdata, dm_wdata;
  logic        core_gnt, core_rvalid, dm_gnt, dm_rvalid;
  logic [31:0] core_rdata, dm_rdata;
  logic        dbg_mode, breakpoint, halt_ack;
  logic        tselect, halt_req, hit_pending;
  logic [31:0] tdata1, tdata2_t0, tdata2_t1, tdata3_t0, tdata3_t1;

  int n_pass = 0;
  int n_total = 0;
  logic [31:0] exp_q[$];

  always #5 cpu_clk = ~cpu_clk;

  trig_csr_ctrl #(.DATA_WIDTH(32), .NUM_TRIG(2)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_gnt(core_gnt), .core_rvalid(core_rvalid),
    .core_rdata(core_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .dbg_mode(dbg_mode), .breakpoint(breakpoint), .halt_ack(halt_ack),
    .tselect(tselect), .tdata1(tdata1),
    .tdata2_t0(tdata2_t0), .tdata2_t1(tdata2_t1),
    .tdata3_t0(tdata3_t0), .tdata3_t1(tdata3_t1),
    .halt_req(halt_req), .hit_pending(hit_pending)
  );

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic do_acc(input string tag, input bit is_dm, input bit we,
                        input logic [11:0] a, input logic [31:0] wd,
                        input logic [31:0] exp, input int exp_lat);
    int   n;
    logic g;
    exp_q.push_back(exp);
    if (is_dm) begin
      dm_req = 1'b1; dm_we = we; dm_addr = a; dm_wdata = wd;
    end else begin
      core_req = 1'b1; core_we = we; core_addr = a; core_wdata = wd;
    end
    n = 0;
    g = 1'b0;
    while (!g && n < 20) begin
      tick();
      n++;
      g = is_dm ? dm_gnt : core_gnt;
    end
    check({tag, "_gnt"}, 32'(g), 32'd1);
    if (exp_lat > 0) check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    dm_req = 1'b0;
    core_req = 1'b0;
    tick();
    check({tag, "_rvalid"}, 32'(is_dm ? dm_rvalid : core_rvalid), 32'd1);
    check({tag, "_rdata"}, is_dm ? dm_rdata : core_rdata, exp_q.pop_front());
  endtask

  task automatic contend(input string tag, input bit dm_first,
                         input logic [11:0] a_dm, input logic [31:0] e_dm,
                         input logic [11:0] a_core, input logic [31:0] e_core);
    tick();
    if (dm_first) begin
      exp_q.push_back(e_dm); exp_q.push_back(e_core);
    end else begin
      exp_q.push_back(e_core); exp_q.push_back(e_dm);
    end
    dm_req = 1'b1;   dm_we = 1'b0;   dm_addr = a_dm;
    core_req = 1'b1; core_we = 1'b0; core_addr = a_core;
    tick();
    check({tag, "_dm_gnt1"}, 32'(dm_gnt), 32'(dm_first));
    check({tag, "_core_gnt1"}, 32'(core_gnt), 32'(!dm_first));
    if (dm_first) dm_req = 1'b0; else core_req = 1'b0;
    tick();
    check({tag, "_rvalid1"}, 32'(dm_first ? dm_rvalid : core_rvalid), 32'd1);
    check({tag, "_rdata1"}, dm_first ? dm_rdata : core_rdata, exp_q.pop_front());
    tick();
    tick();
    check({tag, "_gnt2"}, 32'(dm_first ? core_gnt : dm_gnt), 32'd1);
    dm_req = 1'b0;
    core_req = 1'b0;
    tick();
    check({tag, "_rvalid2"}, 32'(dm_first ? core_rvalid : dm_rvalid), 32'd1);
    check({tag, "_rdata2"}, dm_first ? core_rdata : dm_rdata, exp_q.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cpu_rst = 1'b1;
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
    dm_req = 1'b0;   dm_we = 1'b0;   dm_addr = '0;   dm_wdata = '0;
    dbg_mode = 1'b0; breakpoint = 1'b0; halt_ack = 1'b0;
    tick();
    tick();
    cpu_rst = 1'b0;
    check("rst_tdata1", tdata1, 32'h2000_0000);
    check("rst_tselect", 32'(tselect), 32'd0);
    check("rst_tdata2_t0", tdata2_t0, 32'd0);
    check("rst_halt_req", 32'(halt_req), 32'd0);
    check("rst_hit_pending", 32'(hit_pending), 32'd0);
    check("rst_core_gnt", 32'(core_gnt), 32'd0);

    do_acc("core_wr_td2", 1'b0, 1'b1, 12'h7A2, 32'h8000_0100, 32'h8000_0100, 1);
    check("td2_t0_after_wr", tdata2_t0, 32'h8000_0100);
    tick();
    check("rdata_zero_idle", core_rdata, 32'd0);

    contend("cont1", 1'b1, 12'h7A2, 32'h8000_0100, 12'h7A0, 32'd0);
`ifdef TRIG_ARB_RR_EN
    contend("cont2", 1'b0, 12'h7A3, 32'd0, 12'h7A1, 32'h2000_0000);
`else
    contend("cont2", 1'b1, 12'h7A3, 32'd0, 12'h7A1, 32'h2000_0000);
`endif

    do_acc("core_wr_td1", 1'b0, 1'b1, 12'h7A1, 32'h2800_1044, 32'h2000_1044, 0);
    check("td1_core_dmode0", tdata1, 32'h2000_1044);
    do_acc("dm_wr_td1", 1'b1, 1'b1, 12'h7A1, 32'h2800_1044, 32'h2800_1044, 0);
    check("td1_dm_dmode1", tdata1, 32'h2800_1044);
    do_acc("core_wr_locked", 1'b0, 1'b1, 12'h7A2, 32'd0, 32'h8000_0100, 0);
    check("td2_t0_locked", tdata2_t0, 32'h8000_0100);
    do_acc("core_wr_unmapped", 1'b0, 1'b1, 12'h7A4, 32'h0000_1234, 32'd0, 0);

    do_acc("tsel_wr5", 1'b0, 1'b1, 12'h7A0, 32'd5, 32'd0, 0);
    check("tsel_stays0", 32'(tselect), 32'd0);
    do_acc("tsel_wr1", 1'b0, 1'b1, 12'h7A0, 32'd1, 32'd1, 0);
    check("tsel_is1", 32'(tselect), 32'd1);
    check("td1_trig1", tdata1, 32'h2000_0000);
    do_acc("core_wr_td3_t1", 1'b0, 1'b1, 12'h7A3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0);
    check("td3_t1", tdata3_t1, 32'hDEAD_BEEF);
    check("td3_t0", tdata3_t0, 32'd0);

    breakpoint = 1'b1;
    tick();
    breakpoint = 1'b0;
    check("hit_halt_req", 32'(halt_req), 32'd1);
    check("hit_pending1", 32'(hit_pending), 32'd1);
    check("hit_td1_t1", tdata1, 32'h2010_0000);
    repeat (3) tick();
    check("halt_req_held", 32'(halt_req), 32'd1);
    do_acc("dm_tsel0", 1'b1, 1'b1, 12'h7A0, 32'd0, 32'd0, 0);
    check("tsel_back0", 32'(tselect), 32'd0);
    breakpoint = 1'b1;
    tick();
    breakpoint = 1'b0;
    check("bp2_ignored", tdata1, 32'h2800_1044);
    check("halt_req_still", 32'(halt_req), 32'd1);
    halt_ack = 1'b1;
    dbg_mode = 1'b1;
    tick();
    halt_ack = 1'b0;
    check("ack_halt_req0", 32'(halt_req), 32'd0);
    check("halted_pending", 32'(hit_pending), 32'd1);
    tick();
    check("halted_pending2", 32'(hit_pending), 32'd1);
    dbg_mode = 1'b0;
    tick();
    check("resume_pending0", 32'(hit_pending), 32'd0);

    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 12'h7A2; dm_wdata = 32'h0000_1111;
    breakpoint = 1'b1;
    tick();
    check("mid_dm_gnt", 32'(dm_gnt), 32'd1);
    check("mid_halt_req", 32'(halt_req), 32'd1);
    cpu_rst = 1'b1;
    dm_req = 1'b0;
    breakpoint = 1'b0;
    tick();
    check("rst_mid_rvalid", 32'(dm_rvalid), 32'd0);
    check("rst_mid_halt_req", 32'(halt_req), 32'd0);
    check("rst_mid_tdata1", tdata1, 32'h2000_0000);
    cpu_rst = 1'b0;
    tick();
    check("rst_mid_rvalid2", 32'(dm_rvalid), 32'd0);
    check("rst_mid_td2", tdata2_t0, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
